// File: rtl/sample_fifo.sv
// sample_fifo: single-clock sample FIFO with registered usedw/empty/full and 1-cycle read latency.
// Define SAMPLE_FIFO_SHOWAHEAD_EN to make q present the head word continuously.
module sample_fifo #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4096,
  parameter int USEDW_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclr,
  input  logic [DATA_W-1:0] data,
  input  logic              wrreq,
  input  logic              rdreq,
  output logic [DATA_W-1:0] q,
  output logic [USEDW_W-1:0] usedw,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [USEDW_W-1:0] usedw_q, usedw_d;
  logic [DATA_W-1:0] q_q;
  logic empty_q, full_q, clr, wr_acc, rd_acc;
  always_comb begin
    clr      = reset | sclr;
    wr_acc   = wrreq & ~full_q;
    rd_acc   = rdreq & ~empty_q;
    wr_ptr_d = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = rd_ptr_q + AW'(rd_acc);
    usedw_d  = usedw_q + USEDW_W'(wr_acc) - USEDW_W'(rd_acc);
  end
  // storage is never reset so it can map onto block RAM
  always_ff @(posedge clk)
    if (wr_acc && !clr) mem[wr_ptr_q] <= data;
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      q_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= usedw_d == '0;
      full_q   <= usedw_d == USEDW_W'(DEPTH);
`ifdef SAMPLE_FIFO_SHOWAHEAD_EN
      // the next head is the incoming word when it lands in an empty (or just-emptied) FIFO
      q_q <= (usedw_d == '0) ? '0 :
             (usedw_q == '0 || (usedw_q == USEDW_W'(1) && rd_acc)) ? data : mem[rd_ptr_d];
`else
      if (rd_acc) q_q <= mem[rd_ptr_q];
`endif
    end
  end
  assign q     = q_q;
  assign usedw = usedw_q;
  assign empty = empty_q;
  assign full  = full_q;
endmodule

// File: tb/tb_sample_fifo.sv
// tb_sample_fifo: directed vector table plus model-checked sequences for fill, wrap and clear.
module tb_sample_fifo;
  localparam int DW = 16, DEPTH = 4096, UW = 13;
  logic clk = 1'b0, reset, sclr, wrreq, rdreq, empty, full;
  logic [DW-1:0] data, q;
  logic [UW-1:0] usedw;
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] mdl [$];
  logic [DW-1:0] mq = '0;
  always #5 clk = ~clk;
  sample_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .USEDW_W(UW)) dut (
    .clk(clk), .reset(reset), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q), .usedw(usedw), .empty(empty), .full(full));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic w, r, s, rs, input logic [DW-1:0] d);
    @(negedge clk);
    wrreq = w; rdreq = r; sclr = s; reset = rs; data = d;
  endtask
  task automatic cyc(input logic w, r, s, rs, input logic [DW-1:0] d);
    bit wf, we;
    drive(w, r, s, rs, d);
    if (s || rs) begin
      mdl.delete();
      mq = '0;
    end else begin
      wf = mdl.size() == DEPTH;
      we = mdl.size() == 0;
`ifdef SAMPLE_FIFO_SHOWAHEAD_EN
      if (r && !we) void'(mdl.pop_front());
`else
      if (r && !we) mq = mdl.pop_front();
`endif
      if (w && !wf) mdl.push_back(d);
    end
`ifdef SAMPLE_FIFO_SHOWAHEAD_EN
    mq = (mdl.size() != 0) ? mdl[0] : '0;
`endif
    @(posedge clk); #1;
    chk("usedw", 32'(usedw), 32'(mdl.size()));
    chk("empty", 32'(empty), 32'(mdl.size() == 0));
    chk("full", 32'(full), 32'(mdl.size() == DEPTH));
    chk("q", 32'(q), 32'(mq));
  endtask
  typedef struct {
    logic w, r, s;
    logic [DW-1:0] d;
    logic [UW-1:0] eu;
    logic ee, ef;
    logic [DW-1:0] eq, eqs;
  } vec_t;
  vec_t tv [15];
  initial begin
    int wr_n, cyc_n;
    reset = 1'b1; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_usedw", 32'(usedw), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_q", 32'(q), 0);
    //        w     r     s     d        usedw ee    ef    q(normal) q(show-ahead)
    tv[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 16'h0011, 1, 1'b0, 1'b0, 16'h0000, 16'h0011};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 16'h0022, 2, 1'b0, 1'b0, 16'h0000, 16'h0011};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, 1'b0, 1'b0, 16'h0011, 16'h0022};
    tv[5]  = '{1'b1, 1'b1, 1'b0, 16'h0033, 1, 1'b0, 1'b0, 16'h0022, 16'h0033};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 16'h0033, 16'h0000};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 16'h0033, 16'h0000};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 16'h0044, 1, 1'b0, 1'b0, 16'h0033, 16'h0044};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 16'h0055, 0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tv[10] = '{1'b1, 1'b0, 1'b0, 16'h0066, 1, 1'b0, 1'b0, 16'h0000, 16'h0066};
    tv[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 16'h0066, 16'h0000};
    tv[12] = '{1'b1, 1'b1, 1'b0, 16'h0077, 1, 1'b0, 1'b0, 16'h0066, 16'h0077};
    tv[13] = '{1'b1, 1'b1, 1'b0, 16'h0088, 1, 1'b0, 1'b0, 16'h0077, 16'h0088};
    tv[14] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 16'h0088, 16'h0000};
    foreach (tv[i]) begin
      drive(tv[i].w, tv[i].r, tv[i].s, 1'b0, tv[i].d);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_usedw", i), 32'(usedw), 32'(tv[i].eu));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tv[i].ee));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(tv[i].ef));
`ifdef SAMPLE_FIFO_SHOWAHEAD_EN
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(tv[i].eqs));
`else
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(tv[i].eq));
`endif
    end
`ifdef SAMPLE_FIFO_SHOWAHEAD_EN
    mq = tv[14].eqs;
`else
    mq = tv[14].eq;
`endif
    // full block: fill, dropped overflow write, read+write while full, drain
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(i));
    chk("fill_full", 32'(full), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF);
    chk("full_rw_usedw", 32'(usedw), 4095);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("drain_empty", 32'(empty), 1);
    // steady occupancy with simultaneous read and write
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'h0A00 + i));
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, DW'(16'h0B00 + i));
    chk("steady_usedw", 32'(usedw), 5);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    // pointer wrap with bounded occupancy
    wr_n = 0; cyc_n = 0;
    while ((wr_n < 6000 || mdl.size() != 0) && cyc_n < 20000) begin
      logic w;
      w = wr_n < 6000 && (cyc_n % 4) != 3 && mdl.size() < 100;
      cyc(w, (cyc_n % 5) != 4, 1'b0, 1'b0, DW'($urandom));
      if (w) wr_n++;
      cyc_n++;
    end
    chk("wrap_done", 32'(wr_n), 6000);
    // sclr with wrreq discards contents
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'h0C00 + i));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'hDEAD);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0D01);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    // reset mid-read
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'h0E00 + i));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'hDEAD);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0F01);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
